// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and IF/ID loader with a single outstanding variable-latency imem request.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_unit #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
`ifdef FETCH_PERF_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic            clock,
    input  logic            Reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_inst,
    output logic [XLEN-1:0] id_pc4,
    input  logic [1:0]      ex_branch,
    input  logic            ex_zero,
    input  logic [XLEN-1:0] ex_br_target,
    input  logic            ex_jump,
    input  logic [25:0]     ex_jump_index,
    input  logic [XLEN-1:0] ex_pc4
`ifdef FETCH_PERF_EN
    , output logic [CNT_W-1:0] perf_fetch
    , output logic [CNT_W-1:0] perf_stall
    , output logic [CNT_W-1:0] perf_flush
`endif
);
    typedef enum logic {ISSUE, WAIT} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              kill_q, kill_d;
    logic              id_valid_q, id_valid_d;
    logic [XLEN-1:0]   id_inst_q, id_inst_d;
    logic [XLEN-1:0]   id_pc4_q, id_pc4_d;
    logic              redirect, slot_free, load;
    logic [XLEN-1:0]   target, pc4;
    logic              unused_pc4_low;

    assign redirect  = ex_jump | (ex_branch == 2'b01 & ex_zero) | (ex_branch == 2'b10 & ~ex_zero);
    assign target    = ex_jump ? {ex_pc4[XLEN-1:28], ex_jump_index, 2'b00} : ex_br_target;
    assign slot_free = ~id_valid_q | id_ready;
    assign pc4       = pc_q + XLEN'(4);
    assign imem_addr = pc_q;
    assign id_valid  = id_valid_q;
    assign id_inst   = id_inst_q;
    assign id_pc4    = id_pc4_q;
    assign unused_pc4_low = ^ex_pc4[27:0];

    // Issue/wait sequencing, redirect handling and IF/ID load/consume/flush.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        id_valid_d = id_valid_q;
        id_inst_d  = id_inst_q;
        id_pc4_d   = id_pc4_q;
        imem_req   = 1'b0;
        load       = 1'b0;
        if (state_q == ISSUE) begin
            imem_req = slot_free & ~redirect;
            if (redirect)
                pc_d = target;
            else if (slot_free)
                state_d = WAIT;
        end else if (imem_valid) begin
            state_d = ISSUE;
            kill_d  = 1'b0;
            load    = ~kill_q & ~redirect;
            pc_d    = redirect ? target : load ? pc4 : pc_q;
        end else if (redirect) begin
            kill_d = 1'b1;
            pc_d   = target;
        end
        if (load) begin
            id_valid_d = 1'b1;
            id_inst_d  = imem_rdata;
            id_pc4_d   = pc4;
        end else if (id_valid_q & id_ready) begin
            id_valid_d = 1'b0;
        end
        if (redirect)
            id_valid_d = 1'b0;
    end

    // Fetch state, PC and IF/ID registers.
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= ISSUE;
            pc_q       <= RESET_PC;
            kill_q     <= 1'b0;
            id_valid_q <= 1'b0;
            id_inst_q  <= '0;
            id_pc4_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            kill_q     <= kill_d;
            id_valid_q <= id_valid_d;
            id_inst_q  <= id_inst_d;
            id_pc4_q   <= id_pc4_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [CNT_W-1:0] fetch_q, fetch_d, stall_q, stall_d, flush_q, flush_d;

    // Saturating event counters.
    always_comb begin
        fetch_d = fetch_q + CNT_W'(load & ~&fetch_q);
        stall_d = stall_q + CNT_W'(id_valid_q & ~id_ready & ~&stall_q);
        flush_d = flush_q + CNT_W'(redirect & ~&flush_q);
    end

    // Counter registers.
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            fetch_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            fetch_q <= fetch_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign perf_fetch = fetch_q;
    assign perf_stall = stall_q;
    assign perf_flush = flush_q;
`endif
endmodule
